// File: rtl/tube_scan_ctrl.sv
// tube_scan_ctrl: paced 8-digit 7-segment scan scheduler feeding a 74HC595
// frame shifter over valid/ready; optional macro TUBE_LEADING_ZERO_BLANK_EN.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            display enable
//   disp_data     eight hex nibbles, nibble i drives digit i (0 = rightmost)
//   frame_data    {1'b1, seg[6:0] gfedcba active-low, sel[7:0] active-low}
//   frame_valid   frame_data is valid
//   frame_ready   shifter accepts the frame
//   digit_idx     digit currently or last presented
//   overrun       sticky: a scan tick was lost to back-pressure
//
// Build option:
//   TUBE_LEADING_ZERO_BLANK_EN  blank digits above the most significant
//                               nonzero nibble (digit 0 always shown)
//
// DIV = CLK_FREQ / SCAN_HZ must be >= 4.

module tube_scan_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCAN_HZ  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] disp_data,
  output logic [15:0] frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [2:0]  digit_idx,
  output logic        overrun
);

  localparam int DIV = CLK_FREQ / SCAN_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    BLANK
  } state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt;
  logic        tick;
  logic        pending, pending_n;
  logic        overrun_n;
  logic        armed, armed_n;
  logic [31:0] snapshot, snapshot_n;
  logic [15:0] frame_data_n;
  logic        frame_valid_n;
  logic [2:0]  digit_idx_n;

  logic [31:0] src;
  logic [4:0]  nib_pos;
  logic [3:0]  nib;
  logic [6:0]  seg_hex;
  logic [6:0]  seg_cur;
  logic [7:0]  sel;
  logic        accept;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan-rate divider, parked at zero while disabled.
  assign tick = en && (cnt == TOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digit 0 decodes straight from disp_data: that is the cycle the
  // snapshot is being captured, so the whole scan sees one value.
  assign src     = (digit_idx == 3'd0) ? disp_data : snapshot;
  assign nib_pos = {digit_idx, 2'b00};
  assign nib     = src[nib_pos +: 4];
  assign seg_hex = hex2seg(nib);
  assign sel     = ~(8'b1 << digit_idx);
  assign accept  = frame_valid & frame_ready;

`ifdef TUBE_LEADING_ZERO_BLANK_EN
  // All nibbles at or above this digit zero -> leading zero, unless digit 0.
  logic [31:0] upper;
  logic        lz_blank;

  assign upper    = src >> nib_pos;
  assign lz_blank = (digit_idx != 3'd0) && (upper == 32'd0);
  assign seg_cur  = lz_blank ? 7'h7F : seg_hex;
`else
  assign seg_cur  = seg_hex;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      armed       <= 1'b0;
      snapshot    <= '0;
      frame_data  <= 16'hFFFF;
      frame_valid <= 1'b0;
      digit_idx   <= 3'd0;
    end else begin
      state       <= state_n;
      pending     <= pending_n;
      overrun     <= overrun_n;
      armed       <= armed_n;
      snapshot    <= snapshot_n;
      frame_data  <= frame_data_n;
      frame_valid <= frame_valid_n;
      digit_idx   <= digit_idx_n;
    end
  end

  // armed records that scanning ran since the last blank, so exactly one
  // blank frame follows en falling and none follows reset.
  always_comb begin
    state_n       = state;
    pending_n     = pending;
    overrun_n     = overrun;
    armed_n       = armed;
    snapshot_n    = snapshot;
    frame_data_n  = frame_data;
    frame_valid_n = frame_valid;
    digit_idx_n   = digit_idx;

    unique case (state)
      IDLE: begin
        if (!en) begin
          if (armed) begin
            frame_data_n  = 16'hFFFF;
            frame_valid_n = 1'b1;
            state_n       = BLANK;
          end
        end else begin
          armed_n = 1'b1;
          if (tick || pending) begin
            pending_n = 1'b0;
            state_n   = LOAD;
          end
        end
      end
      LOAD: begin
        if (digit_idx == 3'd0) begin
          snapshot_n = disp_data;
        end
        frame_data_n  = {1'b1, seg_cur, sel};
        frame_valid_n = 1'b1;
        state_n       = SEND;
      end
      SEND: begin
        if (accept) begin
          frame_valid_n = 1'b0;
          digit_idx_n   = digit_idx + 3'd1;
          state_n       = IDLE;
        end
      end
      BLANK: begin
        if (accept) begin
          frame_valid_n = 1'b0;
          digit_idx_n   = 3'd0;
          armed_n       = 1'b0;
          state_n       = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // A tick outside IDLE is deferred once; a second one is lost.
    if (tick && state != IDLE) begin
      if (pending) begin
        overrun_n = 1'b1;
      end else begin
        pending_n = 1'b1;
      end
    end

    if (!en) begin
      pending_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// tb_tube_scan_ctrl: directed checks of tube_scan_ctrl with DIV = 10.
// Scenario tasks run in sequence and compare against hand-derived frames.

module tb_tube_scan_ctrl;

  localparam int CLK_FREQ = 1000;
  localparam int SCAN_HZ  = 100;
  localparam int DIV      = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] disp_data = '0;
  logic        frame_ready = 1'b1;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic [2:0]  digit_idx;
  logic        overrun;

  int vec  = 0;
  int errs = 0;

  tube_scan_ctrl #(
    .CLK_FREQ(CLK_FREQ),
    .SCAN_HZ (SCAN_HZ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .disp_data  (disp_data),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .digit_idx  (digit_idx),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    frame_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // n = negedges waited until frame_valid seen, -1 on timeout.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_valid && n < max);
    if (!frame_valid) n = -1;
  endtask

  task automatic test_reset;
    bit quiet;
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vec++;
    if (frame_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_valid: got %b want 0", frame_valid);
    end
    vec++;
    if (frame_data !== 16'hFFFF) begin
      errs++;
      $display("FAIL rst_data: got %h want ffff", frame_data);
    end
    vec++;
    if (digit_idx !== 3'd0) begin
      errs++;
      $display("FAIL rst_idx: got %0d want 0", digit_idx);
    end
    vec++;
    if (overrun !== 1'b0) begin
      errs++;
      $display("FAIL rst_overrun: got %b want 0", overrun);
    end
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (frame_valid) quiet = 1'b0;
    end
    vec++;
    if (!quiet) begin
      errs++;
      $display("FAIL rst_quiet: got frame with en=0 want none");
    end
  endtask

  task automatic test_scan;
    logic [15:0] ef [9];
    int n;
    ef = '{16'hC0FE, 16'hF9FD, 16'hA4FB, 16'hB0F7,
           16'h99EF, 16'h92DF, 16'h82BF, 16'hF87F, 16'hC0FE};
    do_reset();
    disp_data = 32'h76543210;
    frame_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_valid(20, n);
      vec++;
      if (n != ((i == 0) ? DIV + 1 : DIV)) begin
        errs++;
        $display("FAIL scan_gap[%0d]: got %0d want %0d",
                 i, n, (i == 0) ? DIV + 1 : DIV);
      end
      vec++;
      if ({frame_data, digit_idx} !== {ef[i], 3'(i)}) begin
        errs++;
        $display("FAIL scan_frame[%0d]: got %h/%0d want %h/%0d",
                 i, frame_data, digit_idx, ef[i], i % 8);
      end
    end
    vec++;
    if (overrun !== 1'b0) begin
      errs++;
      $display("FAIL scan_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_backpressure;
    int n;
    bit stable;
    do_reset();
    disp_data = 32'h76543210;
    frame_ready = 1'b1;
    en = 1'b1;
    wait_valid(20, n);
    wait_valid(20, n);
    vec++;
    if (frame_data !== 16'hF9FD) begin
      errs++;
      $display("FAIL bp_d1: got %h want f9fd", frame_data);
    end
    @(negedge clk);
    frame_ready = 1'b0;
    wait_valid(20, n);
    vec++;
    if ({frame_data, digit_idx} !== {16'hA4FB, 3'd2}) begin
      errs++;
      $display("FAIL bp_d2: got %h/%0d want a4fb/2", frame_data, digit_idx);
    end
    stable = 1'b1;
    for (int m = 1; m <= 25; m++) begin
      @(negedge clk);
      if (frame_data !== 16'hA4FB || frame_valid !== 1'b1) stable = 1'b0;
      if (m == 12) begin
        vec++;
        if (overrun !== 1'b0) begin
          errs++;
          $display("FAIL bp_pend_only: got overrun %b want 0", overrun);
        end
      end
    end
    vec++;
    if (!stable) begin
      errs++;
      $display("FAIL bp_stable: got change want a4fb held");
    end
    vec++;
    if (overrun !== 1'b1) begin
      errs++;
      $display("FAIL bp_overrun: got %b want 1", overrun);
    end
    frame_ready = 1'b1;
    wait_valid(6, n);
    vec++;
    if (n != 3) begin
      errs++;
      $display("FAIL bp_resume_lat: got %0d want 3", n);
    end
    vec++;
    if ({frame_data, digit_idx} !== {16'hB0F7, 3'd3}) begin
      errs++;
      $display("FAIL bp_d3: got %h/%0d want b0f7/3", frame_data, digit_idx);
    end
  endtask

  task automatic test_tearing;
    logic [15:0] ef [10];
    int n;
    ef = '{16'hC0FE, 16'hF9FD, 16'hA4FB, 16'hB0F7, 16'h99EF,
           16'h92DF, 16'h82BF, 16'hF87F, 16'h8EFE, 16'h8EFD};
    do_reset();
    disp_data = 32'h76543210;
    frame_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_valid(20, n);
      vec++;
      if (frame_data !== ef[i]) begin
        errs++;
        $display("FAIL tear_frame[%0d]: got %h want %h", i, frame_data, ef[i]);
      end
      if (i == 3) disp_data = 32'hFFFFFFFF;
    end
  endtask

  task automatic test_en_toggle;
    logic [15:0] ef [6];
    int n;
    bit quiet;
    ef = '{16'hC0FE, 16'hF9FD, 16'hA4FB, 16'hB0F7, 16'h99EF, 16'h92DF};
    do_reset();
    disp_data = 32'h76543210;
    frame_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_valid(20, n);
      vec++;
      if (frame_data !== ef[i]) begin
        errs++;
        $display("FAIL en_frame[%0d]: got %h want %h", i, frame_data, ef[i]);
      end
    end
    en = 1'b0;
    wait_valid(6, n);
    vec++;
    if (n != 2 || frame_data !== 16'hFFFF) begin
      errs++;
      $display("FAIL en_blank: got %h after %0d want ffff after 2",
               frame_data, n);
    end
    @(negedge clk);
    vec++;
    if (frame_valid !== 1'b0 || digit_idx !== 3'd0) begin
      errs++;
      $display("FAIL en_blank_done: got v%b idx%0d want v0 idx0",
               frame_valid, digit_idx);
    end
    quiet = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (frame_valid) quiet = 1'b0;
    end
    vec++;
    if (!quiet) begin
      errs++;
      $display("FAIL en_quiet: got frame want none");
    end
    en = 1'b1;
    wait_valid(DIV + 6, n);
    vec++;
    if (n < DIV || n > DIV + 2) begin
      errs++;
      $display("FAIL en_resume_lat: got %0d want %0d..%0d", n, DIV, DIV + 2);
    end
    vec++;
    if ({frame_data, digit_idx} !== {16'hC0FE, 3'd0}) begin
      errs++;
      $display("FAIL en_resume: got %h/%0d want c0fe/0", frame_data, digit_idx);
    end
  endtask

  task automatic test_reset_mid_send;
    int n;
    bit quiet;
    do_reset();
    disp_data = 32'h76543210;
    frame_ready = 1'b0;
    en = 1'b1;
    wait_valid(20, n);
    vec++;
    if (n != DIV + 1 || frame_data !== 16'hC0FE) begin
      errs++;
      $display("FAIL rms_first: got %h after %0d want c0fe after %0d",
               frame_data, n, DIV + 1);
    end
    for (int i = 0; i < 20; i++) @(negedge clk);
    vec++;
    if (overrun !== 1'b1) begin
      errs++;
      $display("FAIL rms_overrun: got %b want 1", overrun);
    end
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vec++;
    if (frame_valid !== 1'b0 || frame_data !== 16'hFFFF) begin
      errs++;
      $display("FAIL rms_frame: got v%b %h want v0 ffff",
               frame_valid, frame_data);
    end
    vec++;
    if (digit_idx !== 3'd0 || overrun !== 1'b0) begin
      errs++;
      $display("FAIL rms_state: got idx%0d ovr%b want idx0 ovr0",
               digit_idx, overrun);
    end
    frame_ready = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (frame_valid) quiet = 1'b0;
    end
    vec++;
    if (!quiet) begin
      errs++;
      $display("FAIL rms_no_blank: got frame want none");
    end
  endtask

  task automatic test_leading_zero;
    logic [15:0] ef [16];
    int n;
`ifdef TUBE_LEADING_ZERO_BLANK_EN
    ef = '{16'h92FE, 16'h88FD, 16'hFFFB, 16'hFFF7,
           16'hFFEF, 16'hFFDF, 16'hFFBF, 16'hFF7F,
           16'hC0FE, 16'hFFFD, 16'hFFFB, 16'hFFF7,
           16'hFFEF, 16'hFFDF, 16'hFFBF, 16'hFF7F};
`else
    ef = '{16'h92FE, 16'h88FD, 16'hC0FB, 16'hC0F7,
           16'hC0EF, 16'hC0DF, 16'hC0BF, 16'hC07F,
           16'hC0FE, 16'hC0FD, 16'hC0FB, 16'hC0F7,
           16'hC0EF, 16'hC0DF, 16'hC0BF, 16'hC07F};
`endif
    do_reset();
    disp_data = 32'h000000A5;
    frame_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_valid(20, n);
      vec++;
      if (frame_data !== ef[i]) begin
        errs++;
        $display("FAIL lz_frame[%0d]: got %h want %h", i, frame_data, ef[i]);
      end
      if (i == 7) disp_data = 32'h0;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_backpressure();
    test_tearing();
    test_en_toggle();
    test_reset_mid_send();
    test_leading_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
